// File: rtl/seq_detect_n_if.sv
// Bus bundle for seq_detect_n: serial input side plus match/count results.
// en qualifies A each cycle (valid-only, no backpressure); match/count/count_sat are registered.
interface seq_detect_n_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr;
    logic             A;
    logic             match;
    logic [CNT_W-1:0] count;
    logic             count_sat;
    logic [1:0]       fsm_state;

    modport master (
        output en, clr, A,
        input  match, count, count_sat, fsm_state
    );

    modport slave (
        input  en, clr, A,
        output match, count, count_sat, fsm_state
    );
endinterface

// File: rtl/seq_detect_n.sv
// Parametrised serial sequence detector with overlap/non-overlap mode,
// input enable and a saturating match counter with synchronous clear.
module seq_detect_n #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b1011,
    parameter bit           OVERLAP = 1'b1,
    parameter int           CNT_W   = 8
) (
    input logic         clk,
    input logic         n_reset,
    seq_detect_n_if.slave bus
);
    localparam int               FW      = $clog2(N + 1);
    localparam logic [FW-1:0]    FILL_N  = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (N < 2) begin : g_bad_n
        $error("seq_detect_n: N must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect_n: CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t           state;
    logic [N-1:0]     hist;
    logic [FW-1:0]    fill;
    logic             match_q;
    logic [CNT_W-1:0] count_q;
    logic             count_sat_q;

    logic [N-1:0]     hist_next;
    logic [FW-1:0]    fill_next;
    logic             hit;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        hist_next  = {hist[N-2:0], bus.A};
        fill_next  = (fill == FILL_N) ? fill : fill + FW'(1);
        hit        = bus.en && (fill_next == FILL_N) && (hist_next == PATTERN);
        count_next = (hit && (count_q != CNT_MAX)) ? count_q + CNT_W'(1) : count_q;
    end

    // state mirrors fill (EMPTY/FILLING/ARMED) so it can be observed directly.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= EMPTY;
            hist        <= '0;
            fill        <= '0;
            match_q     <= 1'b0;
            count_q     <= '0;
            count_sat_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (bus.en) begin
                hist <= hist_next;
                if (hit && !OVERLAP) begin
                    fill  <= '0;
                    state <= EMPTY;
                end else begin
                    fill  <= fill_next;
                    state <= (fill_next == FILL_N) ? ARMED : FILLING;
                end
            end
            // clr beats a coincident hit: that hit pulses match but is not counted.
            if (bus.clr) begin
                count_q     <= '0;
                count_sat_q <= 1'b0;
            end else begin
                count_q     <= count_next;
                count_sat_q <= (count_next == CNT_MAX);
            end
        end
    end

    assign bus.match     = match_q;
    assign bus.count     = count_q;
    assign bus.count_sat = count_sat_q;
    assign bus.fsm_state = state;
endmodule
